// File: rtl/spdif_pkg.sv
// Shared constants for the S/PDIF transmitter: preamble patterns, slot layout
// and frame/block geometry.
package spdif_pkg;

    localparam logic [7:0] PREAMBLE_B = 8'b11101000;
    localparam logic [7:0] PREAMBLE_M = 8'b11100010;
    localparam logic [7:0] PREAMBLE_W = 8'b11100100;

    localparam int SLOT_V = 28;
    localparam int SLOT_U = 29;
    localparam int SLOT_C = 30;
    localparam int SLOT_P = 31;

    localparam int SUBBITS_PER_SUBFRAME = 64;
    localparam int FRAMES_PER_BLOCK     = 192;

    typedef enum logic [1:0] {
        PRE_B = 2'd0,
        PRE_M = 2'd1,
        PRE_W = 2'd2
    } preamble_e;

    function automatic logic [7:0] preamble_bits(input preamble_e sel);
        case (sel)
            PRE_B:   return PREAMBLE_B;
            PRE_M:   return PREAMBLE_M;
            default: return PREAMBLE_W;
        endcase
    endfunction

endpackage

// File: rtl/spdif_bmc_enc.sv
// Biphase-mark line encoder: turns preamble subbits and data cells into the
// registered line level, tracking the last driven level.
module spdif_bmc_enc (
    input  logic clk,
    input  logic rst,
    input  logic i_strobe,
    input  logic i_is_pre,
    input  logic i_pre_first,
    input  logic i_pre_bit,
    input  logic i_half,
    input  logic i_bit,
    output logic o_line
);

    logic r_level;
    logic r_base;
    logic w_base;
    logic w_next;

    // Preamble subbits are XORed with the level seen just before the preamble,
    // which is captured on its first subbit and held for the remaining seven.
    always_comb begin
        w_base = i_pre_first ? r_level : r_base;
        w_next = r_level;
        if (i_is_pre) begin
            w_next = i_pre_bit ^ w_base;
        end else if (!i_half) begin
            w_next = ~r_level;
        end else begin
            w_next = i_bit ? ~r_level : r_level;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level <= 1'b0;
            r_base  <= 1'b0;
        end else if (i_strobe) begin
            r_level <= w_next;
            if (i_pre_first) begin
                r_base <= r_level;
            end
        end
    end

    assign o_line = r_level;

endmodule

// File: rtl/spdif_tx.sv
// S/PDIF transmitter: sample handshake, subframe framing, parity and BMC line.
// Optional SPDIF_TX_UNDERRUN_CNT_EN adds a saturating underrun counter output.
module spdif_tx
    import spdif_pkg::*;
#(
    parameter int CLK_PER_SUBBIT      = 4,
    parameter int CLK_PER_SUBBIT_LOG2 = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [23:0]  data_i,
    input  logic         lrck_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [191:0] udata_i,
    input  logic [191:0] cdata_i,
    output logic         signal_o,
    output logic         block_o,
    output logic         underrun_o
`ifdef SPDIF_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]  underrun_cnt_o
`endif
);

    logic [CLK_PER_SUBBIT_LOG2-1:0] r_clk_cnt;
    logic [5:0]   r_subbit;
    logic [7:0]   r_frame;
    logic         r_chan;
    logic         r_full;
    logic [23:0]  r_hold_data;
    logic         r_hold_lrck;
    logic [27:0]  r_word;
    logic [191:0] r_udata;
    logic [191:0] r_cdata;

    logic         w_strobe;
    logic         w_start;
    logic         w_last;
    logic         w_take;
    logic         w_block;
    logic         w_hs;
    logic [7:0]   w_bit_idx;
    logic         w_ubit;
    logic         w_cbit;
    logic [26:0]  w_payload;
    preamble_e    w_pre_sel;
    logic [7:0]   w_pre_pat;
    logic         w_pre_bit;
    logic [4:0]   w_slot;
    logic [4:0]   w_word_idx;
    logic         w_cell_bit;

    // r_word holds slots 4..31, so word bit k is slot k+4.
    always_comb begin
        w_strobe   = !rst && (r_clk_cnt == '0);
        w_start    = w_strobe && (r_subbit == '0);
        w_last     = w_strobe && (r_subbit == 6'(SUBBITS_PER_SUBFRAME - 1));
        w_take     = w_start && r_full && (r_hold_lrck == r_chan);
        w_block    = w_start && !r_chan && (r_frame == '0);
        w_hs       = valid_i && !r_full;
        w_bit_idx  = 8'(FRAMES_PER_BLOCK - 1) - r_frame;
        w_ubit     = w_block ? udata_i[FRAMES_PER_BLOCK-1] : r_udata[w_bit_idx];
        w_cbit     = w_block ? cdata_i[FRAMES_PER_BLOCK-1] : r_cdata[w_bit_idx];
        w_payload  = {w_cbit, w_ubit, !w_take, (w_take ? r_hold_data : 24'd0)};
        w_pre_sel  = r_chan ? PRE_W : ((r_frame == '0) ? PRE_B : PRE_M);
        w_pre_pat  = preamble_bits(w_pre_sel);
        w_pre_bit  = w_pre_pat[3'd7 - r_subbit[2:0]];
        w_slot     = r_subbit[5:1];
        w_word_idx = w_slot - 5'd4;
        w_cell_bit = (w_word_idx < 5'(SLOT_P - 3)) ? r_word[w_word_idx] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_cnt <= '0;
            r_subbit  <= '0;
            r_frame   <= '0;
            r_chan    <= 1'b0;
        end else begin
            r_clk_cnt <= (r_clk_cnt == CLK_PER_SUBBIT_LOG2'(CLK_PER_SUBBIT - 1))
                         ? '0 : r_clk_cnt + CLK_PER_SUBBIT_LOG2'(1);
            if (w_strobe) begin
                r_subbit <= r_subbit + 6'd1;
            end
            if (w_last) begin
                r_chan <= ~r_chan;
                if (r_chan) begin
                    r_frame <= (r_frame == 8'(FRAMES_PER_BLOCK - 1)) ? '0 : r_frame + 8'd1;
                end
            end
        end
    end

    // A handshake cannot coincide with a load (ready is low while full), but
    // giving it priority keeps the register full with the newer sample if it did.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full      <= 1'b0;
            r_hold_data <= '0;
            r_hold_lrck <= 1'b0;
        end else if (w_hs) begin
            r_full      <= 1'b1;
            r_hold_data <= data_i;
            r_hold_lrck <= lrck_i;
        end else if (w_take) begin
            r_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word  <= '0;
            r_udata <= '0;
            r_cdata <= '0;
        end else begin
            if (w_start) begin
                r_word <= {^w_payload, w_payload};
            end
            if (w_block) begin
                r_udata <= udata_i;
                r_cdata <= cdata_i;
            end
        end
    end

    spdif_bmc_enc u_bmc (
        .clk         (clk),
        .rst         (rst),
        .i_strobe    (w_strobe),
        .i_is_pre    (r_subbit[5:3] == 3'd0),
        .i_pre_first (r_subbit == 6'd0),
        .i_pre_bit   (w_pre_bit),
        .i_half      (r_subbit[0]),
        .i_bit       (w_cell_bit),
        .o_line      (signal_o)
    );

    assign ready_o    = !r_full;
    assign block_o    = w_block;
    assign underrun_o = w_start && !w_take;

`ifdef SPDIF_TX_UNDERRUN_CNT_EN
    logic [15:0] r_underrun_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_underrun_cnt <= '0;
        end else if (underrun_o && (r_underrun_cnt != 16'hFFFF)) begin
            r_underrun_cnt <= r_underrun_cnt + 16'd1;
        end
    end

    assign underrun_cnt_o = r_underrun_cnt;
`endif

endmodule

// File: tb/tb_spdif_tx.sv
// Bench for spdif_tx: cycle-count reference model feeding an expected-subframe
// queue, and a line monitor that decodes the BMC stream and checks it.
module tb_spdif_tx;

    localparam int CPS    = 2;
    localparam int SF_CYC = CPS * 64;
    localparam int W      = 29;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [23:0]  data_i = '0;
    logic         lrck_i = 1'b0;
    logic         valid_i = 1'b0;
    logic         ready_o;
    logic [191:0] udata_i = '0;
    logic [191:0] cdata_i = '0;
    logic         signal_o;
    logic         block_o;
    logic         underrun_o;
`ifdef SPDIF_TX_UNDERRUN_CNT_EN
    logic [15:0]  underrun_cnt_o;
`endif

    spdif_tx #(.CLK_PER_SUBBIT(CPS), .CLK_PER_SUBBIT_LOG2(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_i     (data_i),
        .lrck_i     (lrck_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .udata_i    (udata_i),
        .cdata_i    (cdata_i),
        .signal_o   (signal_o),
        .block_o    (block_o),
        .underrun_o (underrun_o)
`ifdef SPDIF_TX_UNDERRUN_CNT_EN
        ,
        .underrun_cnt_o (underrun_cnt_o)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40) $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pre_const(input logic [1:0] code);
        logic [7:0] b, m, w;
        b = 8'b11101000;
        m = 8'b11100010;
        w = 8'b11100100;
        if (code == 2'd0) return b;
        if (code == 2'd1) return m;
        return w;
    endfunction

    // scoreboard: {preamble code[1:0], C, U, V, data[23:0]}
    logic [W-1:0] exp_q[$];

    // reference model: everything follows from the cycle count since reset
    int           c = 0;
    logic         m_full = 1'b0;
    logic         m_lrck = 1'b0;
    logic [23:0]  m_data = '0;
    logic [191:0] m_u = '0;
    logic [191:0] m_c = '0;
    int           m_ucnt = 0;
    logic         prev_rst = 1'b0;

    always @(negedge clk) begin
        int   n, chan, frame;
        logic start, take, blk;
        logic [1:0] code;
        if (rst) begin
            check("rst_block", block_o, 1'b0);
            check("rst_underrun", underrun_o, 1'b0);
            if (prev_rst) begin
                check("rst_signal", signal_o, 1'b0);
                check("rst_ready", ready_o, 1'b1);
`ifdef SPDIF_TX_UNDERRUN_CNT_EN
                check("rst_ucnt", underrun_cnt_o, 16'd0);
`endif
            end
            c = 0;
            m_full = 1'b0;
            m_ucnt = 0;
            exp_q.delete();
        end else begin
            start = (c % SF_CYC) == 0;
            n     = c / SF_CYC;
            chan  = n % 2;
            frame = (n / 2) % 192;
            take  = start && m_full && (m_lrck == chan[0]);
            blk   = start && chan == 0 && frame == 0;
            check("underrun_o", underrun_o, start && !take);
            check("block_o", block_o, blk);
            check("ready_o", ready_o, !m_full);
`ifdef SPDIF_TX_UNDERRUN_CNT_EN
            check("underrun_cnt_o", underrun_cnt_o, 16'(m_ucnt));
`endif
            if (start) begin
                if (blk) begin
                    m_u = udata_i;
                    m_c = cdata_i;
                end
                code = (chan == 1) ? 2'd2 : ((frame == 0) ? 2'd0 : 2'd1);
                exp_q.push_back({code, m_c[191 - frame], m_u[191 - frame], !take,
                                 take ? m_data : 24'd0});
                if (!take && m_ucnt < 65535) m_ucnt++;
            end
            if (valid_i && !m_full) begin
                m_full = 1'b1;
                m_data = data_i;
                m_lrck = lrck_i;
            end else if (take) begin
                m_full = 1'b0;
            end
            c++;
        end
        prev_rst = rst;
    end

    // line monitor: sample each subbit once, decode a subframe after 64 subbits
    int   mc = 0;
    logic last_lvl = 1'b0;
    logic base = 1'b0;
    logic sb [64];

    always @(negedge clk) begin
        int s, miss;
        logic [7:0]  pat;
        logic [27:0] word;
        logic [W-1:0] e;
        if (rst) begin
            mc = 0;
            last_lvl = 1'b0;
        end else begin
            if (mc % CPS == 1) begin
                s = ((mc - 1) / CPS) % 64;
                if (s == 0) base = last_lvl;
                sb[s] = signal_o;
                last_lvl = signal_o;
                if (s == 63) begin
                    for (int i = 0; i < 8; i++) pat[7 - i] = sb[i] ^ base;
                    miss = 0;
                    word = '0;
                    for (int k = 4; k < 32; k++) begin
                        if (sb[2 * k] == sb[2 * k - 1]) miss++;
                        word[k - 4] = sb[2 * k] ^ sb[2 * k + 1];
                    end
                    check("cell_start_transitions", 64'(miss), 64'd0);
                    check("parity_even", 64'(^word), 64'd0);
                    if (exp_q.size() == 0) begin
                        check("expectation_available", 64'd0, 64'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("preamble", pat, pre_const(e[28:27]));
                        check("payload_cuvd", word[26:0], e[26:0]);
                    end
                end
            end
            mc++;
        end
    end

    // driver tasks
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_sample(input logic [23:0] d, input logic l);
        int   waited;
        logic done;
        waited  = 0;
        done    = 1'b0;
        data_i  = d;
        lrck_i  = l;
        valid_i = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (ready_o && !rst) done = 1'b1;
            @(posedge clk);
            #1;
            waited++;
            if (!done && waited > 4 * SF_CYC) begin
                check("handshake_timeout", 64'd0, 64'd1);
                done = 1'b1;
            end
        end
        valid_i = 1'b0;
    endtask

    task automatic wait_cycle(input int want_chan, input int pos);
        int guard;
        guard = 0;
        while (!(((c / SF_CYC) % 2 == want_chan || want_chan < 0) && (c % SF_CYC) == pos)) begin
            idle(1);
            guard++;
            if (guard > 4 * SF_CYC) begin
                check("phase_wait_timeout", 64'd0, 64'd1);
                return;
            end
        end
    endtask

    function automatic logic [191:0] rand192();
        logic [191:0] r;
        for (int i = 0; i < 6; i++) r[i * 32 +: 32] = $urandom();
        return r;
    endfunction

    initial begin
        logic lr;
        cdata_i = 192'd1 << 191;
        udata_i = rand192();
        idle(4);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            send_sample((i % 2 == 1) ? 24'h800000 : 24'h000001, i[0]);
        end
        idle(3 * SF_CYC);

        // right sample offered while a left subframe is next
        wait_cycle(1, 10);
        send_sample(24'h5A5A5A, 1'b1);
        send_sample(24'h123456, 1'b0);
        send_sample(24'hABCDEF, 1'b1);

        lr = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 29) == 0) idle($urandom_range(10, 200));
            if (i % 64 == 0) udata_i = rand192();
            send_sample(24'($urandom()), lr);
            lr = ~lr;
        end

        // reset while subbit 30 is on the line
        idle(SF_CYC);
        wait_cycle(-1, 61);
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_sample(24'($urandom()), i[0]);
        end
        idle(2 * SF_CYC);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1);
    end

endmodule
